// File: rtl/weight_fetch_ctrl_if.sv
// Bundles the start request, weight BRAM read port and output stream handshake
// of the weight fetch controller.
interface weight_fetch_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          start;
    logic [AW-1:0] BRAM_ADDR;
    logic          BRAM_EN;
    logic          BRAM_WE;
    logic [DW-1:0] BRAM_DI;
    logic [DW-1:0] BRAM_DO;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    modport master (
        input  start, BRAM_DO, out_ready,
        output BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_DI,
        output out_data, out_index, out_last, out_valid, busy, done
    );

    modport slave (
        output start, BRAM_DO, out_ready,
        input  BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_DI,
        input  out_data, out_index, out_last, out_valid, busy, done
    );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Streams one row of DEPTH weight words out of a BRAM through a 2-entry
// buffer, issuing reads only when the buffer is guaranteed to have room.
module weight_fetch_ctrl #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input logic             CLK,
    input logic             RST_N,
    weight_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    logic [AW-1:0] counter;
    logic          rd_en;
    logic [DW-1:0] fifo_data  [2];
    logic [AW-1:0] fifo_index [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          done_q;
    logic          head_valid;
    logic          head_last;
    logic          pop;
    logic          last_issue;

    assign head_valid = (count != 2'd0);
    assign head_last  = (fifo_index[rd_ptr] == LAST_ADDR);
    assign pop        = head_valid && bus.out_ready;
    assign last_issue = rd_en && (counter == LAST_ADDR);

    always_comb begin
        count_next = count;
        if (rd_en && !pop)
            count_next = count + 2'd1;
        else if (!rd_en && pop)
            count_next = count - 2'd1;
    end

    // The read enable for the next cycle is decided from the occupancy after
    // this edge, so a read issued next cycle always finds a free slot even if
    // nothing is popped meanwhile.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            counter <= '0;
            rd_en   <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i]  <= '0;
                fifo_index[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            count  <= count_next;
            if (rd_en) begin
                fifo_data[wr_ptr]  <= bus.BRAM_DO;
                fifo_index[wr_ptr] <= counter;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case (state)
                IDLE: begin
                    rd_en <= 1'b0;
                    if (bus.start) begin
                        state   <= FETCH;
                        counter <= '0;
                        rd_en   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (last_issue)
                        state <= DRAIN;
                    else if (rd_en)
                        counter <= counter + 1'b1;
                    rd_en <= !last_issue && (count_next < 2'd2);
                end
                DRAIN: begin
                    rd_en <= 1'b0;
                    if (pop && head_last) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BRAM_ADDR = counter;
    assign bus.BRAM_EN   = rd_en;
    assign bus.BRAM_WE   = 1'b0;
    assign bus.BRAM_DI   = '0;
    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_index = head_valid ? fifo_index[rd_ptr] : '0;
    assign bus.out_last  = head_valid && head_last;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: expected words are queued at start
// and checked against every completed beat.
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    typedef struct packed {
        logic [AW-1:0] index;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    weight_fetch_ctrl_if #(.AW(AW), .DW(DW)) bus();

    weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] mem [32];

    always @(negedge CLK)
        if (bus.BRAM_EN === 1'b1)
            bus.BRAM_DO <= mem[bus.BRAM_ADDR];

    int    n_compared   = 0;
    int    n_mismatched = 0;
    int    cyc          = 0;
    int    t0           = 0;
    beat_t sb[$];
    int    occ          = 0;
    int    first_rel, last_rel, done_rel, beats, done_cnt;
    bit    we_bad       = 1'b0;

    // Mid-cycle sampling of one clock cycle against the scoreboard.
    task automatic observe();
        int    rel;
        bit    beat;
        beat_t got;
        beat_t exp_b;
        rel  = cyc - t0;
        beat = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        if (bus.BRAM_EN === 1'b1) begin
            n_compared++;
            if (occ >= 2) begin
                n_mismatched++;
                $display("[TB] FAIL issue_limit: read at cycle %0d with %0d buffered, required < 2", rel, occ);
            end
        end
        if (beat) begin
            n_compared++;
            got.index = bus.out_index;
            got.data  = bus.out_data;
            got.last  = bus.out_last;
            if (sb.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL unexpected_beat: index %0d data %h, no word expected", got.index, got.data);
            end else begin
                exp_b = sb.pop_front();
                if (got !== exp_b) begin
                    n_mismatched++;
                    $display("[TB] FAIL beat: got index %0d data %h last %b, expected index %0d data %h last %b",
                             got.index, got.data, got.last, exp_b.index, exp_b.data, exp_b.last);
                end
            end
            if (first_rel < 0)
                first_rel = rel;
            last_rel = rel;
            beats++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_rel = rel;
        end
        if (bus.BRAM_WE !== 1'b0 || bus.BRAM_DI !== '0)
            we_bad = 1'b1;
        if (RST_N === 1'b0)
            occ = 0;
        else
            occ = occ + int'(bus.BRAM_EN === 1'b1) - int'(beat);
    endtask

    task automatic step();
        @(negedge CLK);
        observe();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start     = 1'b0;
            bus.out_ready = 1'b1;
            step();
        end
    endtask

    task automatic launch(input int back);
        beat_t b;
        t0        = cyc - back;
        first_rel = -1;
        last_rel  = -1;
        done_rel  = -1;
        beats     = 0;
        done_cnt  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            b.index = AW'(i);
            b.data  = DW'(16'h0100 + i);
            b.last  = (i == DEPTH - 1);
            sb.push_back(b);
        end
    endtask

    // mode 0: ready always; 1: ready low in cycles 5..9; 2: ready on even cycles
    task automatic run_stream(input int mode, input int extra_rel, input int stop_rel, input int budget);
        int rel;
        int k;
        k   = 0;
        rel = cyc - t0;
        while (done_cnt == 0 && rel < stop_rel && k < budget) begin
            bus.start = (rel == 0) || (rel == extra_rel);
            case (mode)
                1:       bus.out_ready = !(rel >= 5 && rel <= 9);
                2:       bus.out_ready = (rel % 2 == 0);
                default: bus.out_ready = 1'b1;
            endcase
            step();
            k++;
            rel = cyc - t0;
        end
        bus.start = 1'b0;
        n_compared++;
        if (k >= budget) begin
            n_mismatched++;
            $display("[TB] FAIL timeout: no done within %0d cycles, %0d beats seen", budget, beats);
        end
    endtask

    task automatic test_reset();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        RST_N         = 1'b0;
        step();
        step();
        n_compared++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.BRAM_EN, bus.BRAM_WE} !== 6'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got %b, expected 000000",
                     {bus.out_valid, bus.out_last, bus.busy, bus.done, bus.BRAM_EN, bus.BRAM_WE});
        end
        n_compared++;
        if (bus.out_data !== '0 || bus.out_index !== '0 || bus.BRAM_ADDR !== '0 || bus.BRAM_DI !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_buses: data %h index %0d addr %0d di %h, expected all 0",
                     bus.out_data, bus.out_index, bus.BRAM_ADDR, bus.BRAM_DI);
        end
        RST_N = 1'b1;
        idle(3);
        n_compared++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: busy %b valid %b, expected 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        launch(0);
        run_stream(0, -1, 1000, 100);
        idle(3);
        n_compared++;
        if (first_rel !== 2 || last_rel !== 29 || done_rel !== 30) begin
            n_mismatched++;
            $display("[TB] FAIL basic_timing: first %0d last %0d done %0d, expected 2 29 30", first_rel, last_rel, done_rel);
        end
        n_compared++;
        if (beats !== DEPTH || done_cnt !== 1 || sb.size() !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL basic_count: beats %0d dones %0d left %0d, expected 28 1 0", beats, done_cnt, sb.size());
        end
    endtask

    task automatic test_backpressure();
        launch(0);
        for (int r = 6; r <= 9; r++) begin
            run_stream(1, -1, r, 50);
            n_compared++;
            if (bus.out_valid !== 1'b1 || bus.out_index !== 5'd3 || bus.out_data !== 16'h0103 || bus.BRAM_EN !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL hold_c%0d: valid %b index %0d data %h en %b, expected 1 3 0103 0",
                         r, bus.out_valid, bus.out_index, bus.out_data, bus.BRAM_EN);
            end
        end
        run_stream(1, -1, 1000, 100);
        idle(3);
        n_compared++;
        if (last_rel !== 34 || done_rel !== 35 || beats !== DEPTH || sb.size() !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_end: last %0d done %0d beats %0d left %0d, expected 34 35 28 0",
                     last_rel, done_rel, beats, sb.size());
        end
    endtask

    task automatic test_toggle();
        launch(0);
        run_stream(2, -1, 1000, 200);
        idle(3);
        n_compared++;
        if (beats !== DEPTH || done_cnt !== 1 || sb.size() !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL toggle_count: beats %0d dones %0d left %0d, expected 28 1 0", beats, done_cnt, sb.size());
        end
    endtask

    task automatic test_start_ignored();
        launch(0);
        run_stream(0, 10, 1000, 100);
        idle(3);
        n_compared++;
        if (beats !== DEPTH || done_cnt !== 1 || done_rel !== 30 || sb.size() !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL restart_ignored: beats %0d dones %0d done %0d left %0d, expected 28 1 30 0",
                     beats, done_cnt, done_rel, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        launch(0);
        run_stream(0, -1, 12, 50);
        RST_N = 1'b0;
        #1;
        n_compared++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.BRAM_EN} !== 5'b0 ||
            bus.out_data !== '0 || bus.out_index !== '0 || bus.BRAM_ADDR !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset: valid %b last %b busy %b done %b en %b data %h index %0d addr %0d, expected all 0",
                     bus.out_valid, bus.out_last, bus.busy, bus.done, bus.BRAM_EN, bus.out_data, bus.out_index, bus.BRAM_ADDR);
        end
        sb.delete();
        bus.start = 1'b0;
        step();
        step();
        RST_N = 1'b1;
        idle(3);
        n_compared++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL wait_idle: busy %b valid %b, expected 0 0", bus.busy, bus.out_valid);
        end
        launch(0);
        run_stream(0, -1, 1000, 100);
        idle(3);
        n_compared++;
        if (first_rel !== 2 || done_rel !== 30 || beats !== DEPTH || sb.size() !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL restart: first %0d done %0d beats %0d left %0d, expected 2 30 28 0",
                     first_rel, done_rel, beats, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        we_bad = 1'b0;
        launch(0);
        run_stream(0, 30, 1000, 100);
        n_compared++;
        if (done_rel !== 30 || beats !== DEPTH) begin
            n_mismatched++;
            $display("[TB] FAIL first_of_pair: done %0d beats %0d, expected 30 28", done_rel, beats);
        end
        launch(1);
        run_stream(0, -1, 1000, 100);
        idle(3);
        n_compared++;
        if (first_rel !== 2 || last_rel !== 29 || done_rel !== 30 || beats !== DEPTH || sb.size() !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL second_of_pair: first %0d last %0d done %0d beats %0d left %0d, expected 2 29 30 28 0",
                     first_rel, last_rel, done_rel, beats, sb.size());
        end
        n_compared++;
        if (we_bad !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL write_port: write enable or data seen nonzero, expected constant 0");
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = DW'(16'h0100 + i);
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_toggle();
        test_start_ignored();
        test_reset_midstream();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
